down_counter_ctrl: RTL and testbench

Controller that sequences a WIDTH-bit down counter for timed events. It accepts a load value through a start/ready handshake and counts down once per clock. It supports pause, abort and auto-reload, and reports each expiry with a one-cycle done pulse and a saturating expiry tally. It sits between control logic and the countdown datapath, which it owns, as the single point that loads, runs and retires countdowns.

---
 rtl/down_counter_ctrl.sv | 102 ++++++++++
 tb/tb_down_counter_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter_ctrl.sv
// Countdown sequencer: loads a value through a start/ready handshake, counts to zero,
// and supports pause, abort, auto-reload and a saturating expiry tally.
module down_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               pause,
  input  logic               abort,
  input  logic               auto_reload,
  output logic               ready,
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic               done,
  output logic [TALLY_W-1:0] tally
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   reload, next_count, next_reload;
  logic [TALLY_W-1:0] next_tally;

  always_comb begin
    next_state  = state;
    next_count  = count;
    next_reload = reload;
    next_tally  = tally;
    case (state)
      IDLE: begin
        if (start) begin
          next_count  = load_val;
          next_reload = load_val;
          next_state  = (load_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
          next_count = '0;
        end else if (pause) begin
          next_state = PAUSE;
        end else if (count <= WIDTH'(1)) begin
          // Terminal step also covers a stray zero so the count can never wrap.
          next_count = '0;
          next_state = DONE;
        end else begin
          next_count = count - 1'b1;
        end
      end
      PAUSE: begin
        if (abort) begin
          next_state = IDLE;
          next_count = '0;
        end else if (!pause) begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (tally != '1) next_tally = tally + 1'b1;
        if (abort) begin
          next_state = IDLE;
          next_count = '0;
        end else if (auto_reload) begin
          next_count = reload;
          next_state = (reload != '0) ? RUN : DONE;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tally  <= '0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      reload <= next_reload;
      tally  <= next_tally;
      ready  <= (next_state == IDLE);
      busy   <= (next_state != IDLE);
      done   <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed bench for down_counter_ctrl; a second instance with TALLY_W=2 checks tally saturation.
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] load_val = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       auto_reload = 1'b0;
  logic       ready, busy, done;
  logic [3:0] count;
  logic [7:0] tally;

  logic       start2 = 1'b0;
  logic [3:0] load_val2 = '0;
  logic       pause2 = 1'b0;
  logic       abort2 = 1'b0;
  logic       auto_reload2 = 1'b0;
  logic       ready2, busy2, done2;
  logic [3:0] count2;
  logic [1:0] tally2;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(4), .TALLY_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .ready(ready), .busy(busy), .count(count), .done(done), .tally(tally)
  );

  down_counter_ctrl #(.WIDTH(4), .TALLY_W(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .load_val(load_val2),
    .pause(pause2), .abort(abort2), .auto_reload(auto_reload2),
    .ready(ready2), .busy(busy2), .count(count2), .done(done2), .tally(tally2)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] lv, input logic p,
                               input logic a, input logic ar);
    start       = s;
    load_val    = lv;
    pause       = p;
    abort       = a;
    auto_reload = ar;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    nextCycle();
    nextCycle();
    checkOutput("reset_ready", int'(ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_tally", int'(tally), 0);
    reset = 1'b0;
    nextCycle();

    // Start while busy is ignored, then reset mid-run
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("busy_start_c0", int'(count), 5);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("busy_start_c1", int'(count), 4);
    nextCycle();
    checkOutput("busy_start_c2", int'(count), 3);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    nextCycle();
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_ready", int'(ready), 1);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_tally", int'(tally), 0);
    reset = 1'b0;
    nextCycle();

    // Basic countdown from 5
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("n5_ready_c0", int'(ready), 0);
    for (int k = 0; k <= 5; k++) begin
      checkOutput($sformatf("n5_count_c%0d", k), int'(count), 5 - k);
      checkOutput($sformatf("n5_done_c%0d", k), int'(done), int'(k == 5));
      nextCycle();
    end
    checkOutput("n5_ready_c6", int'(ready), 1);
    checkOutput("n5_tally", int'(tally), 1);

    // Zero load value goes straight to DONE
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("n0_done_c0", int'(done), 1);
    checkOutput("n0_count_c0", int'(count), 0);
    nextCycle();
    checkOutput("n0_ready_c1", int'(ready), 1);
    checkOutput("n0_done_c1", int'(done), 0);
    checkOutput("n0_tally", int'(tally), 2);

    // Load 4 with pause during cycles 1-2
    begin
      int expCount[8] = '{4, 3, 3, 3, 3, 2, 1, 0};
      applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
      nextCycle();
      for (int k = 0; k <= 7; k++) begin
        applyStimulus(1'b0, 4'd0, (k == 1 || k == 2), 1'b0, 1'b0);
        checkOutput($sformatf("pause_count_c%0d", k), int'(count), expCount[k]);
        checkOutput($sformatf("pause_done_c%0d", k), int'(done), int'(k == 7));
        nextCycle();
      end
      checkOutput("pause_ready_end", int'(ready), 1);
      checkOutput("pause_tally", int'(tally), 3);
    end

    // Abort while paused
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("abort_paused_count", int'(count), 6);
    checkOutput("abort_paused_busy", int'(busy), 1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_count", int'(count), 0);
    checkOutput("abort_ready", int'(ready), 1);
    checkOutput("abort_done", int'(done), 0);
    nextCycle();
    checkOutput("abort_done_after", int'(done), 0);
    checkOutput("abort_tally", int'(tally), 3);

    // Auto-reload with load 3, dropped after the third done pulse
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    nextCycle();
    for (int k = 0; k <= 15; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, (k < 12));
      checkOutput($sformatf("reload_count_c%0d", k), int'(count), 3 - (k % 4));
      checkOutput($sformatf("reload_done_c%0d", k), int'(done), int'((k % 4) == 3));
      checkOutput($sformatf("reload_busy_c%0d", k), int'(busy), 1);
      if (k == 4) checkOutput("reload_tally_c4", int'(tally), 4);
      if (k == 8) checkOutput("reload_tally_c8", int'(tally), 5);
      nextCycle();
    end
    checkOutput("reload_ready_end", int'(ready), 1);
    checkOutput("reload_tally_end", int'(tally), 7);

    // Saturating 2-bit tally on the second instance
    begin
      int expTally[5] = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
        start2 = 1'b1;
        nextCycle();
        start2 = 1'b0;
        checkOutput($sformatf("sat_done_%0d", i), int'(done2), 1);
        nextCycle();
        checkOutput($sformatf("sat_tally_%0d", i), int'(tally2), expTally[i]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
